// File: rtl/srambank_arb.sv
// srambank_arb: two-port round-robin arbiter/sequencer for a 1024x72 single-port SRAM bank.
// Define SRAMBANK_ARB_INIT_EN to zero-fill the bank after reset before accepting commands.
module srambank_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  input  logic              a_rready,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  input  logic              b_rready,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_banksel,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              init_done
);
  logic resp_pending_q, resp_pending_d, resp_port_q, resp_port_d, last_q, last_d;
  logic run, rel_rsp, can_rd, elig_a, elig_b, gnt_a, gnt_b, hs_wr, hs_rd;
`ifdef SRAMBANK_ARB_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = &cnt_q ? RUN : INIT;
    end
  end
  assign run = state_q == RUN;
`else
  assign run = 1'b1;
`endif
  // A read may issue when nothing is outstanding or the outstanding response retires this cycle
  assign rel_rsp = resp_pending_q & (resp_port_q ? b_rready : a_rready);
  assign can_rd  = ~resp_pending_q | rel_rsp;
  assign elig_a  = ~reset & run & a_valid & (a_write | can_rd);
  assign elig_b  = ~reset & run & b_valid & (b_write | can_rd);
  assign gnt_a   = elig_a & (~elig_b | last_q);
  assign gnt_b   = elig_b & ~gnt_a;
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign hs_wr   = gnt_a ? a_write : gnt_b & b_write;
  assign hs_rd   = (gnt_a | gnt_b) & ~hs_wr;
  always_comb begin
    mem_banksel = hs_wr | hs_rd;
    mem_write   = hs_wr;
    mem_read    = hs_rd;
    mem_addr    = gnt_b ? b_addr : a_addr;
    mem_wd      = gnt_b ? b_wdata : a_wdata;
`ifdef SRAMBANK_ARB_INIT_EN
    if (~reset & ~run) begin
      mem_banksel = 1'b1;
      mem_write   = 1'b1;
      mem_addr    = cnt_q;
      mem_wd      = '0;
    end
`endif
  end
  always_comb begin
    resp_pending_d = hs_rd | (resp_pending_q & ~rel_rsp);
    resp_port_d    = hs_rd ? gnt_b : resp_port_q;
    last_d         = (gnt_a | gnt_b) ? gnt_b : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_pending_q <= 1'b0;
      resp_port_q    <= 1'b0;
      last_q         <= 1'b1;
    end else begin
      resp_pending_q <= resp_pending_d;
      resp_port_q    <= resp_port_d;
      last_q         <= last_d;
    end
  end
  assign a_rvalid  = ~reset & resp_pending_q & ~resp_port_q;
  assign b_rvalid  = ~reset & resp_pending_q & resp_port_q;
  assign a_rdata   = mem_dataout;
  assign b_rdata   = mem_dataout;
  assign init_done = run;
endmodule

// File: tb/tb_srambank_arb.sv
// tb_srambank_arb: directed and random stimulus against a transaction-level model of the arbiter and bank.
module tb_srambank_arb;
  localparam int AW = 10;
  localparam int DW = 72;
`ifdef SRAMBANK_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam logic [DW-1:0] V5  = 72'h12_3456789A_BCDEF012;
  localparam logic [DW-1:0] V10 = 72'hA5_0F0F0F0F_DEADBEEF;
  logic clk = 1'b0, reset = 1'b1;
  logic a_valid = 1'b0, a_write = 1'b0, a_rready = 1'b0;
  logic b_valid = 1'b0, b_write = 1'b0, b_rready = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ready, b_ready, a_rvalid, b_rvalid, mem_banksel, mem_read, mem_write, init_done;
  logic [DW-1:0] a_rdata, b_rdata, mem_wd, mem_dataout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] bank [1024];
  logic bank_ok = 1'b0;
  logic [DW-1:0] ref_mem [1024];
  logic pend, pend_port, last_m, run_m;
  logic [DW-1:0] pend_data;
  int init_cnt, gobs, tests = 0, fails = 0;

  srambank_arb dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rready(a_rready), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rready(b_rready), .b_rdata(b_rdata),
    .mem_banksel(mem_banksel), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_dataout(mem_dataout), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Bank: 1-cycle read into a latched output that only reads update
  always @(posedge clk) begin
    if (!bank_ok) begin
      for (int i = 0; i < 1024; i++) bank[i] <= '0;
      bank_ok <= 1'b1;
    end else if (mem_banksel && mem_write) bank[mem_addr] <= mem_wd;
    else if (mem_banksel && mem_read) mem_dataout <= bank[mem_addr];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check DUT outputs against the model, then advance the model at the edge
  task automatic cyc();
    logic rel, crd, ea, eb, ga, gb, wr, rd;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    #1;
    rel = pend && (pend_port ? b_rready : a_rready);
    crd = !pend || rel;
    ea = !reset && run_m && a_valid && (a_write || crd);
    eb = !reset && run_m && b_valid && (b_write || crd);
    ga = ea && (!eb || last_m);
    gb = eb && !ga;
    wr = (ga && a_write) || (gb && b_write);
    rd = (ga || gb) && !wr;
    ad = gb ? b_addr : a_addr;
    wd = gb ? b_wdata : a_wdata;
    gobs = a_ready ? 1 : b_ready ? 2 : 0;
    chk1("a_ready", a_ready, ga);
    chk1("b_ready", b_ready, gb);
    chk1("a_rvalid", a_rvalid, !reset && pend && !pend_port);
    chk1("b_rvalid", b_rvalid, !reset && pend && pend_port);
    if (!reset && pend) chkw(pend_port ? "b_rdata" : "a_rdata", pend_port ? b_rdata : a_rdata, pend_data);
    if (!reset) chk1("init_done", init_done, run_m);
    if (!reset && !run_m) begin
      chk1("init_banksel", mem_banksel, 1'b1);
      chk1("init_write", mem_write, 1'b1);
      chk1("init_read", mem_read, 1'b0);
      chkw("init_addr", DW'(mem_addr), DW'(init_cnt));
      chkw("init_wd", mem_wd, '0);
    end else begin
      chk1("mem_banksel", mem_banksel, wr || rd);
      chk1("mem_write", mem_write, wr);
      chk1("mem_read", mem_read, rd);
      if (wr || rd) chkw("mem_addr", DW'(mem_addr), DW'(ad));
      if (wr) chkw("mem_wd", mem_wd, wd);
    end
    @(posedge clk);
    if (reset) begin
      pend = 1'b0;
      last_m = 1'b1;
      run_m = !INIT_EN;
      init_cnt = 0;
    end else begin
      if (!run_m) begin
        ref_mem[init_cnt] = '0;
        init_cnt++;
        if (init_cnt == 1024) run_m = 1'b1;
      end
      if (wr) ref_mem[ad] = wd;
      if (rd) begin
        pend = 1'b1;
        pend_port = gb;
        pend_data = ref_mem[ad];
      end else if (rel) pend = 1'b0;
      if (ga || gb) last_m = gb;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; a_write = 1'b0; b_write = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    while (!run_m) cyc();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    pend = 1'b0; pend_port = 1'b0; pend_data = '0; last_m = 1'b1; run_m = !INIT_EN; init_cnt = 0; gobs = 0;
    @(negedge clk);
    // Requests held through reset must not be accepted
    a_valid = 1'b1; b_valid = 1'b1;
    cyc();
    cyc();
    chk1("reset_a_ready", a_ready, 1'b0);
    chk1("reset_b_ready", b_ready, 1'b0);
    chk1("reset_banksel", mem_banksel, 1'b0);
    // A holds a read of 0x3FF from reset until granted
    reset = 1'b0; b_valid = 1'b0; a_addr = 10'h3FF; a_rready = 1'b1;
    n = 0;
    while (gobs != 1 && n < 1100) begin
      cyc();
      n++;
    end
    chkw("first_grant_cycle", DW'(n), INIT_EN ? DW'(1025) : DW'(1));
    a_valid = 1'b0;
    #1;
    chk1("rd3ff_rvalid", a_rvalid, 1'b1);
    chkw("rd3ff_rdata", a_rdata, '0);
    cyc();
    // Write then read 0x005 on A
    a_valid = 1'b1; a_write = 1'b1; a_addr = 10'h005; a_wdata = V5;
    cyc();
    a_write = 1'b0;
    cyc();
    a_valid = 1'b0;
    #1;
    chk1("rd5_a_rvalid", a_rvalid, 1'b1);
    chkw("rd5_a_rdata", a_rdata, V5);
    chk1("rd5_b_rvalid", b_rvalid, 1'b0);
    cyc();
    // Back-to-back contending reads alternate starting with A after reset
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 10'h005; b_addr = 10'h3FF; a_rready = 1'b1; b_rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chkw("alt_grant", DW'(gobs), DW'(i % 2 + 1));
    end
    // Stalled A response: B write is accepted, B read waits for a_rready
    b_valid = 1'b0; a_write = 1'b1; a_addr = 10'h010; a_wdata = V10;
    cyc();
    a_write = 1'b0;
    cyc();
    a_valid = 1'b0; a_rready = 1'b0;
    b_valid = 1'b1; b_write = 1'b1; b_addr = 10'h010; b_wdata = '0;
    #1;
    chk1("stall_b_wr_ready", b_ready, 1'b1);
    cyc();
    b_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("stall_b_rd_ready", b_ready, 1'b0);
      chkw("stall_a_rdata", a_rdata, V10);
      cyc();
    end
    a_rready = 1'b1;
    #1;
    chk1("release_b_ready", b_ready, 1'b1);
    cyc();
    b_valid = 1'b0; b_rready = 1'b0;
    #1;
    chkw("stall_b_rdata", b_rdata, '0);
    cyc();
    // Reset while a B response is pending
    chk1("pre_reset_b_rvalid", b_rvalid, 1'b1);
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    cyc();
    #1;
    chk1("post_reset_b_rvalid", b_rvalid, 1'b0);
    chk1("post_reset_a_ready", a_ready, 1'b0);
    chk1("post_reset_b_ready", b_ready, 1'b0);
    cyc();
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    while (!run_m) cyc();
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk1("post_reset_tie_a", a_ready, 1'b1);
    cyc();
    // Random traffic over a small address window to force collisions
    for (int i = 0; i < 600; i++) begin
      a_valid = 1'($urandom_range(0, 1)); a_write = 1'($urandom_range(0, 2) == 0);
      b_valid = 1'($urandom_range(0, 1)); b_write = 1'($urandom_range(0, 2) == 0);
      a_addr = AW'($urandom_range(0, 15)); b_addr = AW'($urandom_range(0, 15));
      a_wdata = {8'($urandom), $urandom, $urandom}; b_wdata = {8'($urandom), $urandom, $urandom};
      a_rready = 1'($urandom_range(0, 3) != 0); b_rready = 1'($urandom_range(0, 3) != 0);
      cyc();
    end
    idle();
    a_rready = 1'b1; b_rready = 1'b1;
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
